// File: rtl/song_recorder.sv
// Records a key_on/key stream as {key, duration} events into a small buffer.
// Rests are stored with key code 15; reads are registered and return {15,0} past count.
module song_recorder #(
  parameter int DEPTH = 32,
  parameter int DUR_W = 26
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rec_start,
  input  logic                       rec_stop,
  input  logic                       key_on,
  input  logic [3:0]                 key,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [3:0]                 rd_key,
  output logic [DUR_W-1:0]           rd_dur,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       recording,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0]       REST_KEY = 4'hF;
  localparam logic [DUR_W-1:0] DUR_MAX  = '1;
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      DEPTH_C  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FIRST = 2'd1,
    S_NOTE       = 2'd2,
    S_REST       = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       key_q, key_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic [3:0]       rd_key_q, rd_key_d;
  logic [DUR_W-1:0] rd_dur_q, rd_dur_d;

  logic             wr_en;
  logic [3:0]       wr_key;
  logic [DUR_W-1:0] wr_dur;
  logic [AW:0]      count_inc;
  logic             active;
  logic [DUR_W-1:0] dur_inc;

  logic [3:0]       mem_key [DEPTH];
  logic [DUR_W-1:0] mem_dur [DEPTH];

  assign active    = key_on && (key != REST_KEY);
  assign dur_inc   = (dur_q == DUR_MAX) ? dur_q : dur_q + DUR_ONE;
  assign count_inc = count_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    dur_d   = dur_q;
    count_d = count_q;
    full_d  = full_q;
    wr_en   = 1'b0;
    wr_key  = key_q;
    wr_dur  = dur_q;

    // rec_stop is tested first in every recording state so it beats key events.
    case (state_q)
      S_IDLE: begin
        if (rec_start) begin
          state_d = S_WAIT_FIRST;
          count_d = '0;
          full_d  = 1'b0;
        end
      end
      S_WAIT_FIRST: begin
        if (rec_stop) begin
          state_d = S_IDLE;
        end else if (active) begin
          state_d = S_NOTE;
          key_d   = key;
          dur_d   = DUR_ONE;
        end
      end
      S_NOTE: begin
        if (rec_stop) begin
          wr_en   = 1'b1;
          state_d = S_IDLE;
        end else if (active && (key == key_q)) begin
          dur_d = dur_inc;
        end else if (active) begin
          wr_en = 1'b1;
          key_d = key;
          dur_d = DUR_ONE;
        end else begin
          wr_en   = 1'b1;
          dur_d   = DUR_ONE;
          state_d = S_REST;
        end
      end
      S_REST: begin
        if (rec_stop) begin
          state_d = S_IDLE;
        end else if (!active) begin
          dur_d = dur_inc;
        end else begin
          wr_en   = 1'b1;
          wr_key  = REST_KEY;
          key_d   = key;
          dur_d   = DUR_ONE;
          state_d = S_NOTE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The write that fills the buffer ends the take; anything latched with it is dropped.
    if (wr_en) begin
      count_d = count_inc;
      if (count_inc == DEPTH_C) begin
        full_d  = 1'b1;
        state_d = S_IDLE;
      end
    end

    if ({1'b0, rd_addr} < count_q) begin
      rd_key_d = mem_key[rd_addr];
      rd_dur_d = mem_dur[rd_addr];
    end else begin
      rd_key_d = REST_KEY;
      rd_dur_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      key_q    <= REST_KEY;
      dur_q    <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      rd_key_q <= REST_KEY;
      rd_dur_q <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      dur_q    <= dur_d;
      count_q  <= count_d;
      full_q   <= full_d;
      rd_key_q <= rd_key_d;
      rd_dur_q <= rd_dur_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_key[count_q[AW-1:0]] <= wr_key;
      mem_dur[count_q[AW-1:0]] <= wr_dur;
    end
  end

  assign rd_key    = rd_key_q;
  assign rd_dur    = rd_dur_q;
  assign count     = count_q;
  assign full      = full_q;
  assign recording = (state_q != S_IDLE);

endmodule

// File: doc/song_recorder.md
SONG_RECORDER -- requirements
Module: song_recorder

Interface
REQ-001 Parameter DEPTH, default 32, number of event entries in the buffer.
REQ-002 Parameter DUR_W, default 26, duration field width in clk cycles.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rec_start  input  1  single-cycle pulse; arms recording.
REQ-006 rec_stop  input  1  single-cycle pulse; ends recording.
REQ-007 key_on  input  1  note-active level, same semantics as the song player output.
REQ-008 key  input  4  note index 0..14; 15 is reserved as REST code.
REQ-009 rd_addr  input  $clog2(DEPTH)  buffer read address.
REQ-010 rd_key  output  4  registered key field of entry rd_addr.
REQ-011 rd_dur  output  DUR_W  registered duration field of entry rd_addr.
REQ-012 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-013 recording  output  1  high in any state other than IDLE.
REQ-014 full  output  1  high once the buffer filled during the last recording.

Function
REQ-015 States SHALL be IDLE, WAIT_FIRST, NOTE, REST; one buffer write maximum per cycle.
REQ-016 "Active" SHALL mean key_on==1 and key!=15; key_on with key==15 SHALL count as inactive.
REQ-017 IDLE: rec_start -> WAIT_FIRST, count<=0, full<=0; rec_stop ignored.
REQ-018 WAIT_FIRST: leading silence discarded; first active cycle -> NOTE, latch key, dur counter<=1.
REQ-019 NOTE: each active cycle with unchanged key SHALL increment dur counter, saturating at 2^DUR_W-1.
REQ-020 NOTE: first inactive cycle SHALL write {latched key, counter}, count+1, counter<=1, -> REST; a note held N cycles records dur N.
REQ-021 NOTE: active cycle with key different from latched key SHALL write old note, latch new key, counter<=1, stay NOTE (legato, no rest entry).
REQ-022 REST: each inactive cycle SHALL increment counter (saturating); first active cycle SHALL write {15, counter}, latch key, counter<=1, -> NOTE; M silent cycles record dur M.
REQ-023 rec_stop in WAIT_FIRST or REST SHALL -> IDLE with no write (trailing rest discarded); in NOTE SHALL write the pending note then -> IDLE.
REQ-024 rec_stop SHALL take priority over a simultaneous key event in the same cycle; rec_start outside IDLE SHALL be ignored.
REQ-025 Any write making count==DEPTH SHALL set full<=1 and -> IDLE next cycle; no further writes; the note latched in the same cycle is discarded.
REQ-026 rd_key/rd_dur SHALL reflect mem[rd_addr] one cycle after rd_addr is presented; rd_addr>=count SHALL return rd_key=15, rd_dur=0.
REQ-027 Reads SHALL be legal in every state; a read of the address being written in the same cycle returns the old data.

Reset
REQ-028 rst SHALL force IDLE, count=0, full=0, recording=0, rd_key=15, rd_dur=0, counter=0 immediately.
REQ-029 Buffer contents need not be cleared; rst mid-recording SHALL discard the pending event.

Verification
REQ-030 rec_start; 5 idle cycles; key=2 active 10 cycles; inactive 4; key=4 active 6; rec_stop -> entries {2,10},{15,4},{4,6}, count=3, recording=0.
REQ-031 key=1 active 3 cycles then key=3 active 5 cycles, inactive, rec_stop -> {1,3},{3,5}, no rest entry between them.
REQ-032 Alternate 1-cycle active/1-cycle inactive with DEPTH=32 -> full=1 after 32nd write, count=32, further key_on produces no writes.
REQ-033 key_on held with key=0 for 2^26+5 cycles (or DUR_W=4, 20 cycles) -> rd_dur saturates at all-ones (15 for DUR_W=4).
REQ-034 rst asserted during NOTE -> outputs at reset values same cycle; later rd_addr=0 returns {15,0}.
REQ-035 key_on=1 with key=15 for 8 cycles in WAIT_FIRST -> stays WAIT_FIRST, count=0.
